// File: rtl/simple_memory_controller_pkg.sv
// Shared definitions for the host-to-memory read bridge: FSM encoding,
// status register bit positions and the default bus width.
package simple_memory_controller_pkg;

    localparam int DEFAULT_SIZE = 16;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    localparam int BUSY_BIT  = 0;
    localparam int VALID_BIT = 1;
    localparam int INTR_BIT  = 2;

endpackage

// File: rtl/simple_memory_controller.sv
// Host register interface bridged to a single-port memory: a host read edge
// launches one memory read, the returned word is held in a data register.
module simple_memory_controller
    import simple_memory_controller_pkg::*;
#(
    parameter int size = DEFAULT_SIZE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cs,
    input  logic            read,
    input  logic            sreg,
    input  logic            dreg,
    input  logic            mem_ready,
    input  logic [size-1:0] mem_data_bus,
    input  logic [size-1:0] host_addr_bus,
    output logic [size-1:0] host_data_bus,
    output logic [size-1:0] mem_addr_bus,
    output logic            intr,
    output logic            mem_cs,
    output logic            mem_read
);

    state_t          state_q, state_d;
    logic [size-1:0] addr_q, addr_d;
    logic [size-1:0] data_q, data_d;
    logic            read_q;
    logic            valid_q, valid_d;
    logic            intr_q, intr_d;
    logic            dread_q, dread_d;

    logic            busy;
    logic            start;
    logic            capture;
    logic            ack;
    logic            dread_hit;
    logic [size-1:0] status;

    assign busy      = (state_q == REQ);
    // Only a fresh read edge with no register selected is a memory request.
    assign start     = read && !read_q && !sreg && !dreg && (state_q == IDLE);
    assign capture   = busy && mem_ready;
    assign ack       = cs && dread_q;
    assign dread_hit = read && dreg && !sreg && valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            read_q  <= 1'b0;
            valid_q <= 1'b0;
            intr_q  <= 1'b0;
            dread_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            read_q  <= read;
            valid_q <= valid_d;
            intr_q  <= intr_d;
            dread_q <= dread_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        valid_d = valid_q;
        intr_d  = intr_q;
        dread_d = dread_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = REQ;
                    addr_d  = host_addr_bus;
                end
            end
            REQ: begin
                if (mem_ready) begin
                    state_d = IDLE;
                    data_d  = mem_data_bus;
                end
            end
            default: state_d = IDLE;
        endcase

        if (ack) begin
            valid_d = 1'b0;
            intr_d  = 1'b0;
            dread_d = 1'b0;
        end
        if (dread_hit) begin
            dread_d = 1'b1;
        end
        // A completing transaction outranks an acknowledge on the same edge.
        if (capture) begin
            valid_d = 1'b1;
            intr_d  = 1'b1;
        end
    end

    always_comb begin
        status            = '0;
        status[BUSY_BIT]  = busy;
        status[VALID_BIT] = valid_q;
        status[INTR_BIT]  = intr_q;
    end

    always_comb begin
        host_data_bus = '0;
        if (read && sreg) begin
            host_data_bus = status;
        end else if (read && dreg) begin
            host_data_bus = data_q;
        end
    end

    assign mem_addr_bus = addr_q;
    assign intr         = intr_q;
    assign mem_cs       = busy;
    assign mem_read     = busy;

endmodule

// File: tb/tb_simple_memory_controller.sv
// Directed bench for simple_memory_controller; captured memory words are
// queued as they are driven and checked when the host reads them back.
module tb_simple_memory_controller;

    logic        clk;
    logic        rst;
    logic        cs;
    logic        read;
    logic        sreg;
    logic        dreg;
    logic        mem_ready;
    logic [15:0] mem_data_bus;
    logic [15:0] host_addr_bus;
    logic [15:0] host_data_bus;
    logic [15:0] mem_addr_bus;
    logic        intr;
    logic        mem_cs;
    logic        mem_read;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] sb_q[$];
    int          req_cnt = 0;
    logic        mr_prev = 1'b0;
    int          cnt0;
    logic [15:0] rd;

    simple_memory_controller #(.size(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .cs           (cs),
        .read         (read),
        .sreg         (sreg),
        .dreg         (dreg),
        .mem_ready    (mem_ready),
        .mem_data_bus (mem_data_bus),
        .host_addr_bus(host_addr_bus),
        .host_data_bus(host_data_bus),
        .mem_addr_bus (mem_addr_bus),
        .intr         (intr),
        .mem_cs       (mem_cs),
        .mem_read     (mem_read)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        mr_prev <= mem_read;
        if (mem_read && !mr_prev) req_cnt <= req_cnt + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic host_rd(input logic s, input logic d, output logic [15:0] v);
        sreg = s;
        dreg = d;
        read = 1'b1;
        #1;
        v = host_data_bus;
        tick();
        read = 1'b0;
        sreg = 1'b0;
        dreg = 1'b0;
    endtask

    task automatic pulse_cs();
        cs = 1'b1;
        tick();
        cs = 1'b0;
    endtask

    task automatic check_data_rd(input string tag);
        logic [15:0] exp;
        host_rd(1'b0, 1'b1, rd);
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: observed %h expected <empty scoreboard>", tag, rd);
        end else begin
            exp = sb_q.pop_front();
            check(tag, rd, exp);
        end
    endtask

    initial begin
        rst = 1'b0; cs = 1'b0; read = 1'b0; sreg = 1'b0; dreg = 1'b0;
        mem_ready = 1'b0; mem_data_bus = '0; host_addr_bus = '0;

        // Reset
        #100;
        check("rst_host_data", host_data_bus, 16'h0000);
        check("rst_mem_addr", mem_addr_bus, 16'h0000);
        check("rst_outs", {13'd0, intr, mem_cs, mem_read}, 16'h0000);
        rst = 1'b1;
        tick();
        host_rd(1'b1, 1'b0, rd);
        check("rst_status", rd, 16'h0000);
        tick();

        // Normal read of 0x00A5 returning 0xBEEF
        host_addr_bus = 16'h00A5;
        read = 1'b1;
        tick();
        read = 1'b0;
        check("nr_req", {14'd0, mem_cs, mem_read}, 16'h0003);
        check("nr_addr", mem_addr_bus, 16'h00A5);
        tick();
        check("nr_wait", {14'd0, mem_cs, mem_read}, 16'h0003);
        mem_ready = 1'b1;
        mem_data_bus = 16'hBEEF;
        sb_q.push_back(16'hBEEF);
        tick();
        mem_ready = 1'b0;
        mem_data_bus = '0;
        check("nr_done", {13'd0, intr, mem_cs, mem_read}, 16'h0004);

        host_rd(1'b1, 1'b0, rd);
        check("nr_status", rd, 16'h0006);
        pulse_cs();
        check("nr_cs_status_only", {15'd0, intr}, 16'h0001);
        check_data_rd("nr_data");
        pulse_cs();
        check("nr_cs_clear", {15'd0, intr}, 16'h0000);
        host_rd(1'b1, 1'b0, rd);
        check("nr_status_after", rd, 16'h0000);
        tick();

        // Held read: one request only
        cnt0 = req_cnt;
        host_addr_bus = 16'h0033;
        read = 1'b1;
        tick();
        tick();
        mem_ready = 1'b1;
        mem_data_bus = 16'h1234;
        sb_q.push_back(16'h1234);
        tick();
        mem_ready = 1'b0;
        tick();
        tick();
        check("held_idle", {14'd0, mem_cs, mem_read}, 16'h0000);
        read = 1'b0;
        tick();
        check("held_req_count", 16'(req_cnt - cnt0), 16'h0001);
        check_data_rd("held_data");
        pulse_cs();

        // mem_ready in IDLE is ignored
        mem_ready = 1'b1;
        mem_data_bus = 16'hDEAD;
        tick();
        tick();
        mem_ready = 1'b0;
        check("idle_rdy_intr", {15'd0, intr}, 16'h0000);
        sb_q.push_back(16'h1234);
        check_data_rd("idle_rdy_data");
        tick();

        // Busy status, ignored edge during REQ, priority
        host_addr_bus = 16'h0077;
        read = 1'b1;
        tick();
        read = 1'b0;
        tick();
        host_rd(1'b1, 1'b0, rd);
        check("busy_status", rd, 16'h0001);
        tick();
        host_addr_bus = 16'h0099;
        read = 1'b1;
        tick();
        read = 1'b0;
        check("busy_addr_kept", mem_addr_bus, 16'h0077);
        check("busy_still_req", {14'd0, mem_cs, mem_read}, 16'h0003);
        mem_ready = 1'b1;
        mem_data_bus = 16'h5555;
        sb_q.push_back(16'h5555);
        tick();
        mem_ready = 1'b0;
        host_rd(1'b1, 1'b1, rd);
        check("prio_status", rd, 16'h0006);
        check_data_rd("prio_data");
        pulse_cs();
        tick();

        // Reset during REQ
        host_addr_bus = 16'h0042;
        read = 1'b1;
        tick();
        read = 1'b0;
        check("mid_req", {15'd0, mem_read}, 16'h0001);
        #1;
        rst = 1'b0;
        #1;
        check("mid_rst_outs", {13'd0, intr, mem_cs, mem_read}, 16'h0000);
        check("mid_rst_addr", mem_addr_bus, 16'h0000);
        #1;
        rst = 1'b1;
        tick();
        host_rd(1'b1, 1'b0, rd);
        check("mid_rst_status", rd, 16'h0000);

        check("sb_drained", 16'(sb_q.size()), 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/simple_memory_controller.md
Name: simple_memory_controller

Overview:
- Bridges a host register interface to a single-port memory with a ready handshake.
- A host "normal read" latches an address and issues a memory read request. The controller waits for mem_ready, captures the returned word into a data register and raises intr.
- The host then reads the status and data registers and acknowledges with a one-cycle cs strobe.
- Sits between the host bus decoder and the memory device model/port.

Parameters:
- size, 16, width of all address and data buses.

Ports:
- clk  in  1  system clock, all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- cs  in  1  host acknowledge strobe; one-cycle pulse after a register read
- read  in  1  host read request
- sreg  in  1  with read: select status register
- dreg  in  1  with read: select data register
- mem_ready  in  1  memory has valid data on mem_data_bus
- mem_data_bus  in  size  memory read data
- host_addr_bus  in  size  host read address
- host_data_bus  out  size  register read data to host
- mem_addr_bus  out  size  address to memory
- intr  out  1  read-complete interrupt, level
- mem_cs  out  1  memory chip select
- mem_read  out  1  memory read strobe

Behaviour:
- Reset (rst=0, asynchronous):
  - state IDLE.
  - data_reg, addr_reg, read_q and all flags are 0.
  - All outputs are 0.
- Start condition: rising edge of read (read=1, read_q=0) with sreg=0 and dreg=0 while in IDLE.
  - Latch host_addr_bus into addr_reg and go to REQ.
  - A read held high does not retrigger; a read edge outside IDLE is ignored.
- FSM states:
  - IDLE: mem_cs=0, mem_read=0; mem_ready is ignored.
  - REQ: mem_cs=1, mem_read=1 (registered), mem_addr_bus=addr_reg, busy=1. Stay until mem_ready=1 is sampled.
  - On that edge: data_reg<=mem_data_bus, valid<=1, intr<=1, go to IDLE. mem_cs and mem_read drop on the same edge.
  - Latency: mem_cs/mem_read are high from the first edge after the read rise until the edge that samples mem_ready.
- mem_addr_bus always drives addr_reg and holds the last address between transactions.
- Status register (sreg=1, read=1), combinational:
  - host_data_bus = {size-3 zeros, intr, valid, busy}.
- Data register (dreg=1, sreg=0, read=1), combinational:
  - host_data_bus = data_reg.
  - Sets the flag dread_seen on each such clock edge while valid=1.
- sreg and dreg both 1: status register wins.
- host_data_bus is 0 when read=0 or when neither register is selected.
- cs acknowledge: on an edge with cs=1 and dread_seen=1, clear intr, valid and dread_seen. data_reg retains its value.
  - cs with dread_seen=0 (e.g. after a status-only read) has no effect.
- New transaction while valid=1 is allowed. It overwrites data_reg and re-raises intr on completion; valid stays 1.
- Reset mid-transaction: immediately returns to IDLE with mem_cs and mem_read deasserted; any pending data is discarded.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=0, REQ=1).
  - Status bit indices (BUSY=0, VALID=1, INTR=2).
  - The default width of 16.
- No sub-module needed: single module containing the FSM, the address/data registers and the host read mux.

Test Plan:
- Reset:
  - Hold rst=0 for 100 ns.
  - Required: all outputs 0.
  - Status read after reset returns 0x0000.
- Normal read:
  - addr 0x00A5; memory returns 0xBEEF with mem_ready pulsed 1 cycle, 2 cycles after mem_read rises.
  - Required: mem_addr_bus=0x00A5.
  - Required: mem_cs and mem_read are high until the mem_ready edge.
  - Required: intr rises the same edge; data_reg=0xBEEF.
- Status then data read:
  - After intr, the sreg read returns 0x0006. The cs pulse leaves intr=1.
  - The dreg read returns 0xBEEF; the following cs pulse clears intr.
  - The next status read returns 0x0000.
- Held read / ignored edges:
  - Hold read=1 for 5 cycles.
  - Required: exactly one memory request.
  - Required: mem_ready pulses in IDLE cause no capture and no intr.
- Priority and busy:
  - sreg=dreg=1 read returns status.
  - A read edge during REQ is ignored.
  - A status read during REQ returns 0x0001.
- Reset mid-REQ:
  - Drive rst low while mem_read=1.
  - Required: mem_cs, mem_read and intr go 0 without waiting for clk.
